// File: rtl/clear_sequencer_pkg.sv
// Shared board geometry, stat widths/limits, scoring constants and FSM encoding.
package clear_sequencer_pkg;

  localparam int unsigned BOARD_W    = 10;
  localparam int unsigned BOARD_H    = 20;
  localparam int unsigned BOARD_SIZE = BOARD_W * BOARD_H;

  localparam int unsigned ROWCNT_W = 5;   // holds 0..BOARD_H
  localparam int unsigned SCORE_W  = 20;
  localparam int unsigned LINES_W  = 14;
  localparam int unsigned LEVEL_W  = 4;
  localparam int unsigned PTS_W    = 15;  // base * (level+1) <= 19200
  localparam int unsigned BASE_W   = 11;
  localparam int unsigned CNT_W    = 4;   // flash phase counter, up to 15

  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(999999);
  localparam logic [LINES_W-1:0] LINES_MAX = LINES_W'(9999);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(15);

  localparam logic [BASE_W-1:0] PTS_SINGLE = BASE_W'(40);
  localparam logic [BASE_W-1:0] PTS_DOUBLE = BASE_W'(100);
  localparam logic [BASE_W-1:0] PTS_TRIPLE = BASE_W'(300);
  localparam logic [BASE_W-1:0] PTS_TETRIS = BASE_W'(1200);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FLASH  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Row r occupies bits [r*BOARD_W +: BOARD_W]; row 0 is the bottom row.
  function automatic logic [BOARD_W-1:0] get_row(input logic [BOARD_SIZE-1:0] board,
                                                 input int unsigned row);
    return board[row*BOARD_W +: BOARD_W];
  endfunction

  // True when every cell of the row is occupied.
  function automatic logic get_row_fill(input logic [BOARD_SIZE-1:0] board,
                                        input int unsigned row);
    return &get_row(board, row);
  endfunction

  // Base points for a clear of n rows; anything from four up scores as a tetris.
  function automatic logic [BASE_W-1:0] base_points(input logic [ROWCNT_W-1:0] n);
    case (n)
      ROWCNT_W'(0): return '0;
      ROWCNT_W'(1): return PTS_SINGLE;
      ROWCNT_W'(2): return PTS_DOUBLE;
      ROWCNT_W'(3): return PTS_TRIPLE;
      default:      return PTS_TETRIS;
    endcase
  endfunction

endpackage

// File: rtl/clear_sequencer_clear.sv
// Combinational clear stage: counts full rows and compacts the survivors downward.
module clear_sequencer_clear
  import clear_sequencer_pkg::*;
(
  input  logic [BOARD_SIZE-1:0] board,
  output logic [BOARD_SIZE-1:0] new_board,
  output logic [ROWCNT_W-1:0]   num_to_clear
);

  // Walk rows bottom-up; non-full rows are packed into the next free destination row.
  always_comb begin
    logic [ROWCNT_W-1:0] dst;
    new_board    = '0;
    num_to_clear = '0;
    dst          = '0;
    for (int unsigned r = 0; r < BOARD_H; r++) begin
      if (get_row_fill(board, r)) begin
        num_to_clear = num_to_clear + ROWCNT_W'(1);
      end else begin
        new_board[dst*BOARD_W +: BOARD_W] = get_row(board, r);
        dst = dst + ROWCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clear_sequencer.sv
// Sequences a locked board through row check, clear flash and commit, and keeps HUD stats.
module clear_sequencer
  import clear_sequencer_pkg::*;
#(
  parameter int unsigned FLASH_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  restart,
  input  logic                  lock_valid,
  output logic                  lock_ready,
  input  logic [BOARD_SIZE-1:0] lock_board,
  output logic [BOARD_SIZE-1:0] board_out,
  output logic                  board_valid,
  output logic [BOARD_H-1:0]    flash_mask,
  output logic                  flash_on,
  output logic                  busy,
  output logic [LINES_W-1:0]    lines_total,
  output logic [SCORE_W-1:0]    score,
  output logic [LEVEL_W-1:0]    level
);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(2 * FLASH_TICKS - 1);

  state_t state, state_nx;

  logic [BOARD_SIZE-1:0] board_q;
  logic [BOARD_SIZE-1:0] stage_q;
  logic [ROWCNT_W-1:0]   n_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [3:0]            lines_mod10;

  logic [BOARD_SIZE-1:0] new_board_c;
  logic [ROWCNT_W-1:0]   n_c;
  logic [BOARD_H-1:0]    row_full_c;

  logic                  capture_c;
  logic                  check_c;
  logic                  flash_tick_c;
  logic                  flash_done_c;
  logic                  commit_c;

  logic [BASE_W-1:0]     base_c;
  logic [4:0]            lvl_p1_c;
  logic [PTS_W-1:0]      pts_c;
  logic [SCORE_W:0]      score_sum_c;
  logic [SCORE_W-1:0]    score_nx_c;
  logic [LINES_W:0]      lines_sum_c;
  logic [LINES_W-1:0]    lines_nx_c;
  logic [4:0]            mod_sum_c;
  logic [1:0]            tens_c;
  logic [3:0]            mod_nx_c;
  logic [4:0]            lvl_sum_c;
  logic [LEVEL_W-1:0]    level_nx_c;

  clear_sequencer_clear u_clear (
    .board        (board_q),
    .new_board    (new_board_c),
    .num_to_clear (n_c)
  );

  // Full-row flags for the flash mask, taken from the captured board.
  always_comb begin
    row_full_c = '0;
    for (int unsigned r = 0; r < BOARD_H; r++) begin
      row_full_c[r] = get_row_fill(board_q, r);
    end
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lock_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      lock_ready <= (state_nx == ST_IDLE);
      busy       <= (state_nx != ST_IDLE);
    end
  end

  // Next-state logic; restart overrides every transition.
  always_comb begin
    state_nx = state;
    if (restart) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (lock_valid) state_nx = ST_CHECK;
        ST_CHECK:  state_nx = (n_c == '0) ? ST_COMMIT : ST_FLASH;
        ST_FLASH:  if (tick && (cnt_q == FLASH_LAST)) state_nx = ST_COMMIT;
        ST_COMMIT: state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Per-state strobes and the commit-time stat arithmetic.
  always_comb begin
    capture_c    = (state == ST_IDLE) && lock_valid && !restart;
    check_c      = (state == ST_CHECK) && !restart;
    flash_tick_c = (state == ST_FLASH) && tick && !restart;
    flash_done_c = flash_tick_c && (cnt_q == FLASH_LAST);
    commit_c     = (state == ST_COMMIT) && !restart;

    base_c      = base_points(n_q);
    lvl_p1_c    = 5'(level) + 5'd1;
    pts_c       = PTS_W'(base_c) * PTS_W'(lvl_p1_c);
    score_sum_c = (SCORE_W + 1)'(score) + (SCORE_W + 1)'(pts_c);
    score_nx_c  = (score_sum_c > (SCORE_W + 1)'(SCORE_MAX)) ? SCORE_MAX : score_sum_c[SCORE_W-1:0];

    lines_sum_c = (LINES_W + 1)'(lines_total) + (LINES_W + 1)'(n_q);
    lines_nx_c  = (lines_sum_c > (LINES_W + 1)'(LINES_MAX)) ? LINES_MAX : lines_sum_c[LINES_W-1:0];

    // A clear of up to 20 rows on top of 0..9 carried lines crosses at most two tens.
    mod_sum_c = 5'(lines_mod10) + 5'(n_q);
    tens_c    = 2'd0;
    mod_nx_c  = mod_sum_c[3:0];
    if (mod_sum_c >= 5'd20) begin
      tens_c   = 2'd2;
      mod_nx_c = 4'(mod_sum_c - 5'd20);
    end else if (mod_sum_c >= 5'd10) begin
      tens_c   = 2'd1;
      mod_nx_c = 4'(mod_sum_c - 5'd10);
    end
    lvl_sum_c  = 5'(level) + 5'(tens_c);
    level_nx_c = (lvl_sum_c > 5'(LEVEL_MAX)) ? LEVEL_MAX : lvl_sum_c[LEVEL_W-1:0];
  end

  // Datapath: capture, staging, flash phase tracking, commit and stats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      board_q     <= '0;
      stage_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      flash_mask  <= '0;
      flash_on    <= 1'b0;
      board_out   <= '0;
      board_valid <= 1'b0;
      score       <= '0;
      lines_total <= '0;
      level       <= '0;
      lines_mod10 <= '0;
    end else begin
      board_valid <= commit_c;
      if (restart) begin
        flash_mask  <= '0;
        flash_on    <= 1'b0;
        score       <= '0;
        lines_total <= '0;
        level       <= '0;
        lines_mod10 <= '0;
      end else begin
        if (capture_c) begin
          board_q <= lock_board;
        end
        if (check_c) begin
          n_q        <= n_c;
          flash_mask <= row_full_c;
          stage_q    <= new_board_c;
          flash_on   <= (n_c != '0);
          cnt_q      <= '0;
        end
        if (flash_tick_c) begin
          flash_on <= flash_done_c ? 1'b0 : ~flash_on;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        if (commit_c) begin
          board_out   <= stage_q;
          flash_mask  <= '0;
          score       <= score_nx_c;
          lines_total <= lines_nx_c;
          level       <= level_nx_c;
          lines_mod10 <= mod_nx_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_clear_sequencer.sv
// Directed bench for clear_sequencer with hand-computed expectations.
module tb_clear_sequencer;
  import clear_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  tick;
  logic                  restart;
  logic                  lock_valid;
  logic                  lock_ready;
  logic [BOARD_SIZE-1:0] lock_board;
  logic [BOARD_SIZE-1:0] board_out;
  logic                  board_valid;
  logic [BOARD_H-1:0]    flash_mask;
  logic                  flash_on;
  logic                  busy;
  logic [LINES_W-1:0]    lines_total;
  logic [SCORE_W-1:0]    score;
  logic [LEVEL_W-1:0]    level;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  clear_sequencer #(.FLASH_TICKS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .restart     (restart),
    .lock_valid  (lock_valid),
    .lock_ready  (lock_ready),
    .lock_board  (lock_board),
    .board_out   (board_out),
    .board_valid (board_valid),
    .flash_mask  (flash_mask),
    .flash_on    (flash_on),
    .busy        (busy),
    .lines_total (lines_total),
    .score       (score),
    .level       (level)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Rows flagged in full are all ones; every other row is a distinct partial pattern.
  function automatic logic [BOARD_SIZE-1:0] mk_board(input logic [BOARD_H-1:0] full);
    logic [BOARD_SIZE-1:0] b;
    logic [BOARD_W-1:0]    row;
    b = '0;
    for (int unsigned r = 0; r < BOARD_H; r++) begin
      row = full[r] ? {BOARD_W{1'b1}} : (BOARD_W'(10'h100) | BOARD_W'(r));
      b[r*BOARD_W +: BOARD_W] = row;
    end
    return b;
  endfunction

  // Expected result when exactly the bottom k rows are full.
  function automatic logic [BOARD_SIZE-1:0] shift_down(input logic [BOARD_SIZE-1:0] b,
                                                       input int unsigned k);
    return b >> (k * BOARD_W);
  endfunction

  // Transfer one board, hold tick high through the flash, stop on board_valid.
  task automatic run_board(input logic [BOARD_SIZE-1:0] b, output logic [BOARD_H-1:0] m);
    int k;
    lock_board = b;
    lock_valid = 1'b1;
    cyc();
    lock_valid = 1'b0;
    cyc();
    m    = flash_mask;
    tick = 1'b1;
    k    = 0;
    while (!board_valid && k < 40) begin
      cyc();
      k++;
    end
    tick = 1'b0;
    check("run_valid_seen", board_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BOARD_SIZE-1:0] a_brd, b_brd, c_brd, t_brd, exp_b, exp_t;
    logic [BOARD_H-1:0]    m;
    logic                  seen;

    a_brd = mk_board(20'h0);
    b_brd = mk_board(20'h1);
    t_brd = mk_board(20'hF);
    c_brd = a_brd >> 1;
    exp_b = shift_down(b_brd, 1);
    exp_t = shift_down(t_brd, 4);

    rst_n = 1'b0; tick = 1'b0; restart = 1'b0; lock_valid = 1'b0; lock_board = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_board_out", board_out, '0);
    check("rst_board_valid", board_valid, 1'b0);
    check("rst_flash_on", flash_on, 1'b0);
    check("rst_flash_mask", flash_mask, '0);
    check("rst_score", score, '0);
    check("rst_lines", lines_total, '0);
    check("rst_level", level, '0);
    check("rst_lock_ready", lock_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // No full rows: CHECK, COMMIT, then valid in cycle 3.
    lock_board = a_brd; lock_valid = 1'b1;
    cyc();
    lock_valid = 1'b0; lock_board = '1;
    check("nc_lock_ready_c1", lock_ready, 1'b0);
    check("nc_busy_c1", busy, 1'b1);
    cyc();
    check("nc_valid_c2", board_valid, 1'b0);
    check("nc_flash_on_c2", flash_on, 1'b0);
    cyc();
    check("nc_valid_c3", board_valid, 1'b1);
    check("nc_lock_ready_c3", lock_ready, 1'b1);
    check("nc_board_out", board_out, a_brd);
    check("nc_score", score, 0);
    cyc();
    check("nc_valid_pulse", board_valid, 1'b0);

    // Single line, tick every other cycle.
    lock_board = b_brd; lock_valid = 1'b1;
    cyc();
    lock_valid = 1'b0;
    cyc();
    check("s1_flash_mask", flash_mask, 20'h00001);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s1_flash_on_%0d", i), flash_on, (i % 2 == 0) ? 1'b1 : 1'b0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    check("s1_valid", board_valid, 1'b1);
    check("s1_board_out", board_out, exp_b);
    check("s1_score", score, 40);
    check("s1_lines", lines_total, 1);
    check("s1_level", level, 0);
    check("s1_mask_cleared", flash_mask, '0);
    check("s1_flash_off", flash_on, 1'b0);

    // Restart together with a transfer request: stats clear, transfer refused.
    restart = 1'b1; lock_valid = 1'b1; lock_board = a_brd;
    cyc();
    restart = 1'b0; lock_valid = 1'b0;
    check("rs_score", score, 0);
    check("rs_lines", lines_total, 0);
    check("rs_lock_ready", lock_ready, 1'b1);
    check("rs_board_out_kept", board_out, exp_b);
    cyc(); cyc(); cyc();
    check("rs_no_valid", board_valid, 1'b0);

    // Tetrises crossing a tens boundary, then a double and a triple.
    run_board(t_brd, m);
    check("t1_mask", m, 20'h0000F);
    check("t1_board_out", board_out, exp_t);
    check("t1_score", score, 1200);
    check("t1_lines", lines_total, 4);
    run_board(t_brd, m);
    check("t2_score", score, 2400);
    check("t2_lines", lines_total, 8);
    check("t2_level", level, 0);
    run_board(t_brd, m);
    check("t3_score", score, 3600);
    check("t3_lines", lines_total, 12);
    check("t3_level", level, 1);
    run_board(t_brd, m);
    check("t4_score", score, 6000);
    check("t4_lines", lines_total, 16);
    check("t4_level", level, 1);
    run_board(mk_board(20'h00021), m);
    check("d_mask", m, 20'h00021);
    check("d_score", score, 6200);
    check("d_lines", lines_total, 18);
    run_board(mk_board(20'h80003), m);
    check("tr_mask", m, 20'h80003);
    check("tr_score", score, 6800);
    check("tr_lines", lines_total, 21);
    check("tr_level", level, 2);

    // Saturation: 80 tetrises from a fresh game.
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    for (int i = 0; i < 80; i++) run_board(t_brd, m);
    check("sat_score", score, 999999);
    check("sat_level", level, 15);
    check("sat_lines", lines_total, 320);

    // Reset during the third flash tick.
    lock_board = b_brd; lock_valid = 1'b1;
    cyc();
    lock_valid = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    tick = 1'b1; rst_n = 1'b0;
    cyc();
    tick = 1'b0; rst_n = 1'b1;
    check("mr_board_out", board_out, '0);
    check("mr_flash_on", flash_on, 1'b0);
    check("mr_flash_mask", flash_mask, '0);
    check("mr_score", score, 0);
    check("mr_level", level, 0);
    check("mr_lock_ready", lock_ready, 1'b1);
    check("mr_busy", busy, 1'b0);
    seen = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      seen = seen | board_valid;
      cyc();
    end
    tick = 1'b0;
    check("mr_no_valid", seen, 1'b0);

    // Restart during the third flash tick.
    run_board(b_brd, m);
    check("mq_pre_score", score, 40);
    lock_board = b_brd; lock_valid = 1'b1;
    cyc();
    lock_valid = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    tick = 1'b1; restart = 1'b1;
    cyc();
    tick = 1'b0; restart = 1'b0;
    check("mq_score", score, 0);
    check("mq_lines", lines_total, 0);
    check("mq_flash_on", flash_on, 1'b0);
    check("mq_flash_mask", flash_mask, '0);
    check("mq_lock_ready", lock_ready, 1'b1);
    check("mq_board_out_kept", board_out, exp_b);
    seen = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      seen = seen | board_valid;
      cyc();
    end
    tick = 1'b0;
    check("mq_no_valid", seen, 1'b0);

    // Back-to-back transfers with lock_valid held high.
    lock_board = a_brd; lock_valid = 1'b1;
    cyc();
    check("bb_busy_first", lock_ready, 1'b0);
    lock_board = c_brd;
    cyc();
    cyc();
    check("bb_valid_first", board_valid, 1'b1);
    check("bb_ready_with_valid", lock_ready, 1'b1);
    check("bb_board_first", board_out, a_brd);
    cyc();
    lock_valid = 1'b0;
    check("bb_second_accepted", busy, 1'b1);
    cyc();
    cyc();
    check("bb_valid_second", board_valid, 1'b1);
    check("bb_board_second", board_out, c_brd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
